// File: rtl/sc_mult_window_pkg.sv
// Shared constants for the stochastic multiplier: LFSR tap masks, mode encoding, seed cleanup.
// Latency: n/a (package only).
// Backpressure: n/a.
package sc_mult_window_pkg;

  // Product gate selection, latched together with the operands.
  typedef enum logic {
    SC_UNIPOLAR = 1'b0,  // AND of the two streams
    SC_BIPOLAR  = 1'b1   // XNOR of the two streams
  } sc_mode_e;

  // Feedback tap masks (bit positions XORed into bit0 after a left shift).
  localparam logic [31:0] SC_TAPS_W16 = 32'h0000_B400;  // taps 15,13,12,10
  localparam logic [31:0] SC_TAPS_W31 = 32'h4800_0000;  // taps 30,27

  function automatic logic [31:0] sc_taps(input int w);
    logic [31:0] taps;
    taps = SC_TAPS_W31;
    if (w == 16) taps = SC_TAPS_W16;
    return taps;
  endfunction

  // An all-zero LFSR is a lock-up state, so a seed that truncates to zero becomes 1.
  function automatic logic [31:0] sc_seed_sanitise(input logic [31:0] seed, input int w);
    logic [31:0] mask;
    logic [31:0] s;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    s    = seed & mask;
    if (s == 32'd0) s = 32'd1;
    return s;
  endfunction

endpackage

// File: rtl/sc_mult_window_if.sv
// Operand/readback bundle between the stochastic test top and the multiplier.
// Latency: n/a (wiring only).
// Backpressure: none; start is a request sampled only when the block is idle.
// Ports: start/cont/mode/prob_a/prob_b towards the multiplier; busy/sn_out/result/
//   result_bp/result_valid back from it.
interface sc_mult_window_if #(
  parameter int N_BITS   = 4,
  parameter int WIN_LOG2 = 3
) ();

  logic                  start;
  logic                  cont;
  logic                  mode;
  logic [N_BITS-1:0]     prob_a;
  logic [N_BITS-1:0]     prob_b;
  logic                  busy;
  logic                  sn_out;
  logic [WIN_LOG2:0]     result;
  logic [WIN_LOG2+1:0]   result_bp;
  logic                  result_valid;

  modport master (
    output start, cont, mode, prob_a, prob_b,
    input  busy, sn_out, result, result_bp, result_valid
  );

  modport slave (
    input  start, cont, mode, prob_a, prob_b,
    output busy, sn_out, result, result_bp, result_valid
  );

endinterface

// File: rtl/sc_mult_window_lfsr.sv
// Free-running Fibonacci LFSR (shift left, bit0 = XOR of taps) for one stochastic number generator.
// Latency: new state every clock from reset release.
// Backpressure: none, never stalls.
// Ports: clk, rst_n (async active-low, loads SEED), o_bits = low OUT_W bits of the state.
module sc_mult_window_lfsr
  import sc_mult_window_pkg::*;
#(
  parameter int W     = 31,
  parameter int SEED  = 1,
  parameter int OUT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [OUT_W-1:0] o_bits
);

  localparam logic [W-1:0] TAPS      = W'(sc_taps(W));
  localparam logic [W-1:0] SEED_INIT = W'(sc_seed_sanitise(32'(SEED), W));

  logic [W-1:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED_INIT;
    end else begin
      r_state <= {r_state[W-2:0], ^(r_state & TAPS)};
    end
  end

  assign o_bits = r_state[OUT_W-1:0];

endmodule

// File: rtl/sc_mult_window.sv
// Stochastic multiplier: two LFSR-driven SNGs, AND/XNOR product, 2**WIN_LOG2-bit window count.
// Latency: start accepted at E0 -> result_valid high after edge E0+2**WIN_LOG2+2.
// Backpressure: start ignored while busy; cont=1 chains windows back-to-back with no gap.
// Ports: clk, rst_n (async active-low), bus (slave modport of sc_mult_window_if).
module sc_mult_window
  import sc_mult_window_pkg::*;
#(
  parameter int N_BITS   = 4,
  parameter int WIN_LOG2 = 3,
  parameter int LFSR_W   = 31,
  parameter int SEED_A   = 1,
  parameter int SEED_B   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  sc_mult_window_if.slave  bus
);

  localparam int WIN = 1 << WIN_LOG2;
  // The window counter runs from 0 at E0 up to WIN+1 at the final edge.
  localparam int CW = WIN_LOG2 + 2;
  // Counter value seen at the first accumulating edge (E3): the two pipeline
  // stages in front of sn_out have to fill before product bits are counted.
  localparam logic [CW-1:0]         CNT_FIRST = CW'(2);
  localparam logic [CW-1:0]         CNT_LAST  = CW'(WIN + 1);
  localparam logic [WIN_LOG2+1:0]   BP_OFFS   = (WIN_LOG2 + 2)'(WIN);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                r_state;
  logic [N_BITS-1:0]     r_op_a;
  logic [N_BITS-1:0]     r_op_b;
  sc_mode_e              r_mode;
  logic                  r_sn_a;
  logic                  r_sn_b;
  logic                  r_sn_out;
  logic [CW-1:0]         r_cnt;
  logic [WIN_LOG2:0]     r_acc;
  logic [WIN_LOG2:0]     r_result;
  logic [WIN_LOG2+1:0]   r_result_bp;
  logic                  r_result_valid;

  logic [N_BITS-1:0]     w_rnd_a;
  logic [N_BITS-1:0]     w_rnd_b;
  logic [WIN_LOG2:0]     w_sum;
  logic [WIN_LOG2+1:0]   w_bp;
  logic                  w_last;

  sc_mult_window_lfsr #(.W(LFSR_W), .SEED(SEED_A), .OUT_W(N_BITS)) u_lfsr_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_bits (w_rnd_a)
  );

  sc_mult_window_lfsr #(.W(LFSR_W), .SEED(SEED_B), .OUT_W(N_BITS)) u_lfsr_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_bits (w_rnd_b)
  );

  // Accumulator holds at most WIN-1 bits, so adding the last bit cannot overflow.
  assign w_sum  = r_acc + {{WIN_LOG2{1'b0}}, r_sn_out};
  assign w_bp   = {w_sum, 1'b0} - BP_OFFS;
  assign w_last = (r_state == ST_RUN) && (r_cnt == CNT_LAST);

  // SNG comparators and product gate run every cycle; only the counter decides what is counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sn_a   <= 1'b0;
      r_sn_b   <= 1'b0;
      r_sn_out <= 1'b0;
    end else begin
      r_sn_a   <= (w_rnd_a < r_op_a);
      r_sn_b   <= (w_rnd_b < r_op_b);
      r_sn_out <= (r_mode == SC_BIPOLAR) ? ~(r_sn_a ^ r_sn_b) : (r_sn_a & r_sn_b);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_op_a         <= '0;
      r_op_b         <= '0;
      r_mode         <= SC_UNIPOLAR;
      r_cnt          <= '0;
      r_acc          <= '0;
      r_result       <= '0;
      r_result_bp    <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_op_a  <= bus.prob_a;
            r_op_b  <= bus.prob_b;
            r_mode  <= sc_mode_e'(bus.mode);
            r_cnt   <= '0;
            r_acc   <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_last) begin
            r_result       <= w_sum;
            r_result_bp    <= w_bp;
            r_result_valid <= 1'b1;
            r_acc          <= '0;
            if (bus.cont) begin
              // The product pipe is already full, so the next window starts
              // accumulating on the very next edge.
              r_cnt <= CNT_FIRST;
            end else begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt >= CNT_FIRST) r_acc <= w_sum;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy         = (r_state == ST_RUN);
  assign bus.sn_out       = r_sn_out;
  assign bus.result       = r_result;
  assign bus.result_bp    = r_result_bp;
  assign bus.result_valid = r_result_valid;

endmodule

// File: tb/tb_sc_mult_window.sv
module tb_sc_mult_window;

  localparam int WA = 8;     // window of the small instance
  localparam int WB = 256;   // window of the wide instance

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sc_mult_window_if #(.N_BITS(4), .WIN_LOG2(3)) bus_a ();
  sc_mult_window_if #(.N_BITS(8), .WIN_LOG2(8)) bus_b ();

  sc_mult_window #(.N_BITS(4), .WIN_LOG2(3), .LFSR_W(31), .SEED_A(1), .SEED_B(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  sc_mult_window #(.N_BITS(8), .WIN_LOG2(8), .LFSR_W(16), .SEED_A(1), .SEED_B(2)) dut_wide (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  int n_cmp = 0;
  int n_err = 0;
  int ecnt  = 0;   // rising edges since reset release

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_step(input logic [31:0] s, input int w);
    logic fb;
    if (w == 16) fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    else         fb = s[30] ^ s[27];
    return ((s << 1) | {31'd0, fb}) & ((32'd1 << w) - 32'd1);
  endfunction

  // Ones in window widx of a run accepted at reset-relative edge e0. Product bit j
  // of window 0 comes from the generator states after e0+j edges (seeds 1 and 2).
  function automatic int ref_window(input int w, input int nbits, input int win, input int e0,
                                    input int widx, input int pa, input int pb, input int md);
    logic [31:0] sa;
    logic [31:0] sb;
    int          cnt;
    int          va;
    int          vb;
    bit          ba;
    bit          bb;
    sa  = 32'd1;
    sb  = 32'd2;
    cnt = 0;
    for (int k = 0; k < e0 + widx * win; k++) begin
      sa = ref_step(sa, w);
      sb = ref_step(sb, w);
    end
    for (int j = 0; j < win; j++) begin
      va = int'(sa) % (1 << nbits);
      vb = int'(sb) % (1 << nbits);
      ba = (va < pa);
      bb = (vb < pb);
      if (md != 0) cnt += (ba == bb) ? 1 : 0;
      else         cnt += (ba && bb) ? 1 : 0;
      sa = ref_step(sa, w);
      sb = ref_step(sb, w);
    end
    return cnt;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive_ops(input int pa, input int pb, input int md);
    bus_a.prob_a = 4'(pa);
    bus_a.prob_b = 4'(pb);
    bus_a.mode   = md[0];
  endtask

  // One window on the small instance; with noise, pins and start toggle while busy
  // and start is held high on the final edge (must not be accepted).
  task automatic run_a(input int pa, input int pb, input int md, input bit noise,
                       output int res, output int bp);
    int e0;
    int exp;
    bit got;
    @(negedge clk);
    drive_ops(pa, pb, md);
    bus_a.cont  = 1'b0;
    bus_a.start = 1'b1;
    e0 = ecnt + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
    check("busy_after_start", int'(bus_a.busy), 1);
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      if (bus_a.result_valid) begin
        got = 1'b1;
      end else begin
        if (noise) begin
          drive_ops($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1));
          bus_a.start = $urandom_range(0, 1) == 1;
          if (ecnt == e0 + WA + 1) bus_a.start = 1'b1;
        end
        @(negedge clk);
      end
    end
    bus_a.start = 1'b0;
    check("valid_seen", int'(got), 1);
    check("latency", ecnt - e0, WA + 2);
    exp = ref_window(31, 4, WA, e0, 0, pa, pb, md);
    res = int'(bus_a.result);
    bp  = $signed(bus_a.result_bp);
    check("result", res, exp);
    check("result_bp", bp, 2 * exp - WA);
    check("busy_fell", int'(bus_a.busy), 0);
    @(negedge clk);
    check("valid_one_cycle", int'(bus_a.result_valid), 0);
    check("busy_stays_idle", int'(bus_a.busy), 0);
    check("result_hold", int'(bus_a.result), exp);
  endtask

  initial begin
    int res;
    int bp;
    int e0;
    int exp;
    int seen;
    int drops;
    bit got;
    int pa;
    int pb;
    int md;

    bus_a.start = 1'b0; bus_a.cont = 1'b0; bus_a.mode = 1'b0;
    bus_a.prob_a = '0;  bus_a.prob_b = '0;
    bus_b.start = 1'b0; bus_b.cont = 1'b0; bus_b.mode = 1'b0;
    bus_b.prob_a = '0;  bus_b.prob_b = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", int'(bus_a.busy), 0);
    check("rst_sn_out", int'(bus_a.sn_out), 0);
    check("rst_result", int'(bus_a.result), 0);
    check("rst_result_bp", int'(bus_a.result_bp), 0);
    check("rst_valid", int'(bus_a.result_valid), 0);
    rst_n = 1'b1;

    // unipolar, A stream all zero
    run_a(0, 15, 0, 1'b0, res, bp);
    check("t1_result", res, 0);
    check("t1_result_bp", bp, -8);

    // bipolar, both streams all zero -> all product bits one, full count
    run_a(0, 0, 1, 1'b0, res, bp);
    check("t2_result", res, 8);
    check("t2_result_bp", bp, 8);

    // largest operands: never all ones
    run_a(15, 15, 0, 1'b0, res, bp);

    // continuous mode: four windows back-to-back
    @(negedge clk);
    pa = 11; pb = 6; md = 1;
    drive_ops(pa, pb, md);
    bus_a.cont  = 1'b1;
    bus_a.start = 1'b1;
    e0 = ecnt + 1;
    @(negedge clk);
    bus_a.start = 1'b0;
    drops = 0;
    for (int w = 0; w < 4; w++) begin
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        if (bus_a.result_valid) got = 1'b1;
        else begin
          if (!bus_a.busy) drops++;
          @(negedge clk);
        end
      end
      check("cont_valid_seen", int'(got), 1);
      check("cont_latency", ecnt - e0, WA + 2 + w * WA);
      exp = ref_window(31, 4, WA, e0, w, pa, pb, md);
      check("cont_result", int'(bus_a.result), exp);
      if (w == 2) bus_a.cont = 1'b0;
      if (w < 3) check("cont_busy_kept", int'(bus_a.busy), 1);
      @(negedge clk);
    end
    check("cont_busy_never_dropped", drops, 0);
    check("cont_busy_end", int'(bus_a.busy), 0);

    // randomized windows with start pulses and pin changes while busy
    for (int i = 0; i < 10; i++) begin
      run_a($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 1'b1, res, bp);
    end

    // reset in the middle of a window
    @(negedge clk);
    drive_ops(15, 15, 0);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(bus_a.busy), 0);
    check("mid_rst_sn_out", int'(bus_a.sn_out), 0);
    check("mid_rst_result", int'(bus_a.result), 0);
    check("mid_rst_result_bp", int'(bus_a.result_bp), 0);
    check("mid_rst_valid", int'(bus_a.result_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (bus_a.result_valid || bus_a.busy) seen++;
    end
    check("no_activity_after_rst", seen, 0);
    run_a(9, 13, 0, 1'b0, res, bp);

    // wide instance: 256-bit window, half times half
    @(negedge clk);
    bus_b.prob_a = 8'd128;
    bus_b.prob_b = 8'd128;
    bus_b.mode   = 1'b0;
    bus_b.start  = 1'b1;
    e0 = ecnt + 1;
    @(negedge clk);
    bus_b.start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      if (bus_b.result_valid) got = 1'b1;
      else @(negedge clk);
    end
    check("wide_valid_seen", int'(got), 1);
    check("wide_latency", ecnt - e0, WB + 2);
    exp = ref_window(16, 8, WB, e0, 0, 128, 128, 0);
    check("wide_result", int'(bus_b.result), exp);
    check("wide_result_bp", $signed(bus_b.result_bp), 2 * exp - WB);
    check("wide_in_range", int'(bus_b.result >= 48 && bus_b.result <= 80), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
